xclk_divider_multi: RTL and testbench

//   Multi-channel, runtime-programmable clock-enable divider generating camera XCLK-style

---
 rtl/xclk_divider_multi_pkg.sv | 17 +
 rtl/xclk_channel.sv | 111 +++++++++++
 rtl/xclk_divider_multi.sv | 38 +++
 tb/tb_xclk_divider_multi.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/xclk_divider_multi_pkg.sv
// Shared constants and FSM state type for the multi-channel XCLK divider.
package xclk_divider_multi_pkg;

  localparam int unsigned F_CPU   = 100_000_000;
  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  function automatic int unsigned xclk_freq_hz(input int unsigned div);
    return F_CPU / div;
  endfunction

endpackage

// File: rtl/xclk_channel.sv
// One divider channel: run/drain FSM, phase counter, active/pending divisor
// and registered square-wave output with edge strobes.
module xclk_channel
  import xclk_divider_multi_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_n_reset,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_xclk,
  output logic             o_rise_stb,
  output logic             o_fall_stb,
  output logic             o_running
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             xclk_q, xclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [DIV_W-1:0] load_val;
  logic             wrap;

  always_comb begin
    load_val = (i_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : i_div;
    wrap     = (count_q == div_q - DIV_W'(1));
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Draining lingers through the count-0 cycle after the wrap so the final
  // falling edge (and its strobe) is still seen while running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_RUN;
      ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_enable)               state_d = ST_RUN;
        else if (count_q == '0)     state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (state_q == ST_IDLE) begin
      count_d = '0;
      if (i_div_load)      div_d = load_val;
      else if (pend_vld_q) div_d = pend_q;
      pend_vld_d = 1'b0;
    end else if (wrap) begin
      count_d = '0;
      if (i_div_load)      div_d = load_val;
      else if (pend_vld_q) div_d = pend_q;
      pend_vld_d = 1'b0;
    end else begin
      count_d = count_q + DIV_W'(1);
      if (i_div_load) begin
        pend_d     = load_val;
        pend_vld_d = 1'b1;
      end
    end
    if (state_d == ST_IDLE) count_d = '0;
    xclk_d = (state_d != ST_IDLE) && (count_d >= (div_d >> 1));
    rise_d = xclk_d & ~xclk_q;
    fall_d = ~xclk_d & xclk_q;
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      count_q    <= '0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      xclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      xclk_q     <= xclk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  always_comb begin
    o_running  = (state_q != ST_IDLE);
    o_xclk     = xclk_q;
    o_rise_stb = rise_q;
    o_fall_stb = fall_q;
  end

endmodule

// File: rtl/xclk_divider_multi.sv
// Multi-channel programmable XCLK divider; slices the buses and replicates
// one independent xclk_channel per output.
module xclk_divider_multi
  import xclk_divider_multi_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic [N_CH-1:0]       i_enable,
  input  logic [N_CH*DIV_W-1:0] i_div,
  input  logic [N_CH-1:0]       i_div_load,
  output logic [N_CH-1:0]       o_xclk,
  output logic [N_CH-1:0]       o_rise_stb,
  output logic [N_CH-1:0]       o_fall_stb,
  output logic [N_CH-1:0]       o_running
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    xclk_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .i_clk     (i_clk),
      .i_n_reset (i_n_reset),
      .i_enable  (i_enable[k]),
      .i_div     (i_div[k*DIV_W +: DIV_W]),
      .i_div_load(i_div_load[k]),
      .o_xclk    (o_xclk[k]),
      .o_rise_stb(o_rise_stb[k]),
      .o_fall_stb(o_fall_stb[k]),
      .o_running (o_running[k])
    );
  end

endmodule

// File: tb/tb_xclk_divider_multi.sv
// Randomized bench for xclk_divider_multi against a per-channel period/position model.
module tb_xclk_divider_multi;

  localparam int N_CH  = 2;
  localparam int DIV_W = 8;

  logic                  clk = 1'b0;
  logic                  n_reset;
  logic [N_CH-1:0]       enable;
  logic [N_CH*DIV_W-1:0] div_bus;
  logic [N_CH-1:0]       div_load;
  logic [N_CH-1:0]       xclk, rise_stb, fall_stb, running;

  xclk_divider_multi #(
    .N_CH       (N_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(4)
  ) dut (
    .i_clk     (clk),
    .i_n_reset (n_reset),
    .i_enable  (enable),
    .i_div     (div_bus),
    .i_div_load(div_load),
    .o_xclk    (xclk),
    .o_rise_stb(rise_stb),
    .o_fall_stb(fall_stb),
    .o_running (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: a channel is either off or sitting at position pos within a period
  // of length per; output is high in the upper ceil(per/2) positions.
  int m_pos [N_CH];
  int m_per [N_CH];
  int m_pend[N_CH];
  bit m_act [N_CH];
  bit m_stop[N_CH];
  bit m_x   [N_CH];
  bit m_rise[N_CH];
  bit m_fall[N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_pos[c] = 0; m_per[c] = 4; m_pend[c] = -1;
      m_act[c] = 0; m_stop[c] = 0;
      m_x[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input bit en_i, input bit ld_i, input int v);
    int cv;
    bit oldx;
    cv   = (v < 2) ? 2 : v;
    oldx = m_x[c];
    if (!m_act[c]) begin
      if (ld_i) m_per[c] = cv;
      else if (m_pend[c] >= 0) m_per[c] = m_pend[c];
      m_pend[c] = -1;
      if (en_i) begin
        m_act[c] = 1; m_pos[c] = 0; m_stop[c] = 0;
      end
    end else if (m_stop[c] && !en_i && m_pos[c] == 0) begin
      m_act[c] = 0;
      if (ld_i) m_pend[c] = cv;
    end else begin
      if (m_pos[c] == m_per[c] - 1) begin
        if (ld_i) m_per[c] = cv;
        else if (m_pend[c] >= 0) m_per[c] = m_pend[c];
        m_pend[c] = -1;
        m_pos[c]  = 0;
      end else begin
        m_pos[c]++;
        if (ld_i) m_pend[c] = cv;
      end
      m_stop[c] = !en_i;
    end
    m_x[c]    = m_act[c] && (m_pos[c] >= m_per[c] / 2);
    m_rise[c] = m_x[c] && !oldx;
    m_fall[c] = !m_x[c] && oldx;
  endtask

  task automatic compare_all(input string phase);
    for (int c = 0; c < N_CH; c++) begin
      check_eq($sformatf("%s xclk[%0d]", phase, c),    int'(xclk[c]),     int'(m_x[c]));
      check_eq($sformatf("%s rise[%0d]", phase, c),    int'(rise_stb[c]), int'(m_rise[c]));
      check_eq($sformatf("%s fall[%0d]", phase, c),    int'(fall_stb[c]), int'(m_fall[c]));
      check_eq($sformatf("%s running[%0d]", phase, c), int'(running[c]),  int'(m_act[c]));
    end
  endtask

  initial begin
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] ld;
    int              dv[N_CH];
    bit              rst_done;

    rst_done = 0;
    en       = '0;
    n_reset  = 1'b0;
    enable   = '0;
    div_bus  = '0;
    div_load = '0;
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    compare_all("reset");

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      n_reset = 1'b1;
      if (cyc == 0) en[0] = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        if (cyc >= 40 && $urandom_range(39, 0) == 0) en[c] = ~en[c];
        ld[c] = (cyc >= 40) && ($urandom_range(24, 0) == 0);
        dv[c] = ($urandom_range(19, 0) == 0) ? int'($urandom_range(255, 0))
                                             : int'($urandom_range(12, 0));
        div_bus[c*DIV_W +: DIV_W] = DIV_W'(dv[c]);
      end
      enable   = en;
      div_load = ld;
      @(posedge clk);
      for (int c = 0; c < N_CH; c++) model_step(c, en[c], ld[c], dv[c]);
      #1;
      compare_all("run");

      if (!rst_done && cyc >= 2000 && m_x[0]) begin
        rst_done = 1;
        #2;
        n_reset = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("async_rst");
      end
    end

    check_eq("mid_reset_exercised", int'(rst_done), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
